// File: rtl/ccis_c1tx_wr_buffer.sv
// CCI-S channel-1 Tx buffer: in-order FIFO between the AFU and the FIU c1 Tx port.
// Strips reserved header fields, gives wrValid priority, and produces a registered AFU almost-full.

package ccis_c1tx_pkg;

    typedef struct packed {
        logic [5:0]  rsvd2;
        logic [3:0]  req_type;
        logic [5:0]  rsvd1;
        logic [31:0] address;
        logic [1:0]  rsvd0;
        logic [12:0] mdata;
    } t_ccis_ReqMemHdr;

    typedef struct packed {
        t_ccis_ReqMemHdr hdr;
        logic [511:0]    data;
        logic            wrValid;
        logic            intrValid;
    } t_if_ccis_c1_Tx;

endpackage

module ccis_c1tx_wr_buffer
    import ccis_c1tx_pkg::*;
#(
    parameter int unsigned N_ENTRIES      = 16,
    parameter int unsigned ALM_FULL_SLACK = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  t_if_ccis_c1_Tx               afu_c1Tx,
    output logic                         afu_c1TxAlmFull,
    output t_if_ccis_c1_Tx               fiu_c1Tx,
    input  logic                         fiu_c1TxAlmFull,
    output logic [$clog2(N_ENTRIES):0]   occupancy
);

    localparam int unsigned PTR_W = $clog2(N_ENTRIES);
    localparam int unsigned CNT_W = PTR_W + 1;

    t_if_ccis_c1_Tx mem [N_ENTRIES];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    t_if_ccis_c1_Tx   fiu_q, fiu_d;
    logic             almfull_q, almfull_d;
    logic             drop_q, drop_d;

    logic             in_valid, empty, full, enq, deq;
    t_if_ccis_c1_Tx   scrubbed;

    always_comb begin
        in_valid = afu_c1Tx.wrValid | afu_c1Tx.intrValid;
        empty    = (count_q == '0);
        full     = (count_q == CNT_W'(N_ENTRIES));
        deq      = !empty && !fiu_c1TxAlmFull;
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        enq      = in_valid && (!full || deq);

        scrubbed = afu_c1Tx;
        scrubbed.hdr.rsvd0 = '0;
        scrubbed.hdr.rsvd1 = '0;
        scrubbed.hdr.rsvd2 = '0;
        if (afu_c1Tx.wrValid) begin
            scrubbed.intrValid = 1'b0;
        end

        wr_ptr_d  = wr_ptr_q + PTR_W'(enq);
        rd_ptr_d  = rd_ptr_q + PTR_W'(deq);
        count_d   = count_q + CNT_W'(enq) - CNT_W'(deq);
        almfull_d = ((CNT_W'(N_ENTRIES) - count_d) <= CNT_W'(ALM_FULL_SLACK));
        drop_d    = drop_q | (in_valid && !enq);

        fiu_d = '0;
        if (deq) begin
            fiu_d = mem[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            fiu_q     <= '0;
            almfull_q <= 1'b1;
            drop_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            fiu_q     <= fiu_d;
            almfull_q <= almfull_d;
            drop_q    <= drop_d;
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr_q] <= scrubbed;
        end
    end

    assign fiu_c1Tx        = fiu_q;
    assign afu_c1TxAlmFull = almfull_q;
    assign occupancy       = count_q;

    overflow_never_seen: assert property (@(posedge clk) disable iff (reset) !drop_q);

endmodule

// File: tb/tb_ccis_c1tx_wr_buffer.sv
// Randomized directed bench for ccis_c1tx_wr_buffer against a queue-based reference model.
module tb_ccis_c1tx_wr_buffer;
    import ccis_c1tx_pkg::*;

    localparam int unsigned N     = 16;
    localparam int unsigned SLACK = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    t_if_ccis_c1_Tx afu_c1Tx = '0;
    logic           afu_c1TxAlmFull;
    t_if_ccis_c1_Tx fiu_c1Tx;
    logic           fiu_c1TxAlmFull = 1'b0;
    logic [4:0]     occupancy;

    ccis_c1tx_wr_buffer #(.N_ENTRIES(N), .ALM_FULL_SLACK(SLACK)) dut (
        .clk             (clk),
        .reset           (reset),
        .afu_c1Tx        (afu_c1Tx),
        .afu_c1TxAlmFull (afu_c1TxAlmFull),
        .fiu_c1Tx        (fiu_c1Tx),
        .fiu_c1TxAlmFull (fiu_c1TxAlmFull),
        .occupancy       (occupancy)
    );

    always #5 clk = ~clk;

    int unsigned ntot  = 0;
    int unsigned npass = 0;

    t_if_ccis_c1_Tx q[$];
    t_if_ccis_c1_Tx exp_fiu = '0;
    logic           exp_af  = 1'b1;
    t_if_ccis_c1_Tx idle    = '0;

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic t_if_ccis_c1_Tx scrub(input t_if_ccis_c1_Tx a);
        t_if_ccis_c1_Tx r = a;
        r.hdr.rsvd0 = '0;
        r.hdr.rsvd1 = '0;
        r.hdr.rsvd2 = '0;
        if (r.wrValid) r.intrValid = 1'b0;
        return r;
    endfunction

    function automatic t_if_ccis_c1_Tx rand_req(input logic wr, input logic intr, input logic [12:0] md);
        t_if_ccis_c1_Tx r;
        for (int i = 0; i < 16; i++) r.data[i*32 +: 32] = $urandom();
        r.hdr.address  = $urandom();
        r.hdr.req_type = 4'($urandom());
        r.hdr.rsvd0    = 2'($urandom());
        r.hdr.rsvd1    = 6'($urandom());
        r.hdr.rsvd2    = 6'($urandom());
        r.hdr.mdata    = md;
        r.wrValid      = wr;
        r.intrValid    = intr;
        return r;
    endfunction

    // One clock edge of the reference: pop first (frees a slot), then push.
    task automatic model_step(input t_if_ccis_c1_Tx a, input logic fa);
        exp_fiu = '0;
        if (q.size() > 0 && !fa) exp_fiu = q.pop_front();
        if (a.wrValid || a.intrValid) begin
            if (q.size() < N) q.push_back(scrub(a));
        end
        exp_af = ((N - q.size()) <= SLACK);
    endtask

    task automatic compare();
        chk("fiu_wrValid", 1024'(fiu_c1Tx.wrValid), 1024'(exp_fiu.wrValid));
        chk("fiu_intrValid", 1024'(fiu_c1Tx.intrValid), 1024'(exp_fiu.intrValid));
        if (exp_fiu.wrValid || exp_fiu.intrValid)
            chk("fiu_payload", 1024'(fiu_c1Tx), 1024'(exp_fiu));
        chk("occupancy", 1024'(occupancy), 1024'(q.size()));
        chk("afu_almfull", 1024'(afu_c1TxAlmFull), 1024'(exp_af));
    endtask

    task automatic cycle(input t_if_ccis_c1_Tx a, input logic fa);
        afu_c1Tx        = a;
        fiu_c1TxAlmFull = fa;
        @(posedge clk);
        #1;
        model_step(a, fa);
        compare();
        afu_c1Tx = '0;
    endtask

    task automatic check_reset_state();
        chk("rst_fiu_wrValid", 1024'(fiu_c1Tx.wrValid), 1024'(0));
        chk("rst_fiu_intrValid", 1024'(fiu_c1Tx.intrValid), 1024'(0));
        chk("rst_occupancy", 1024'(occupancy), 1024'(0));
        chk("rst_almfull", 1024'(afu_c1TxAlmFull), 1024'(1));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        q.delete();
        exp_fiu = '0;
        exp_af  = 1'b1;
        check_reset_state();
        repeat (2) begin
            @(posedge clk);
            #1;
            check_reset_state();
        end
        reset = 1'b0;
    endtask

    initial begin
        t_if_ccis_c1_Tx r;
        int unsigned i;
        logic fa;

        #2;
        do_reset();

        // Idle after reset
        cycle(idle, 1'b0);
        cycle(idle, 1'b0);

        // Single write with reserved fields all ones
        r = rand_req(1'b1, 1'b0, 13'h5);
        r.hdr.address = 32'h1000;
        r.hdr.rsvd0 = '1;
        r.hdr.rsvd1 = '1;
        r.hdr.rsvd2 = '1;
        cycle(r, 1'b0);
        cycle(idle, 1'b0);
        chk("single_addr", 1024'(fiu_c1Tx.hdr.address), 1024'(32'h1000));
        chk("single_rsvd", 1024'({fiu_c1Tx.hdr.rsvd2, fiu_c1Tx.hdr.rsvd1, fiu_c1Tx.hdr.rsvd0}), 1024'(0));
        cycle(idle, 1'b0);

        // Backpressure fill: stream until almFull is seen, then use the slack
        i = 0;
        while (!exp_af && i < 32) begin
            cycle(rand_req(1'b1, 1'b0, 13'(i)), 1'b1);
            i++;
        end
        chk("fill_almfull_at", 1024'(i), 1024'(N - SLACK));
        repeat (SLACK) begin
            cycle(rand_req(1'b1, 1'b0, 13'(i)), 1'b1);
            i++;
        end
        chk("fill_full", 1024'(occupancy), 1024'(N));

        // Enqueue and dequeue together while full
        cycle(rand_req(1'b1, 1'b0, 13'(i)), 1'b0);
        chk("full_simul_first_md", 1024'(fiu_c1Tx.hdr.mdata), 1024'(0));
        chk("full_simul_occ", 1024'(occupancy), 1024'(N));

        i = 0;
        while (q.size() > 0 && i < 64) begin
            cycle(idle, 1'b0);
            i++;
        end
        chk("drain_done", 1024'(q.size()), 1024'(0));
        cycle(idle, 1'b0);

        // Mixed order: W, I, W, W+I
        cycle(rand_req(1'b1, 1'b0, 13'h100), 1'b0);
        cycle(rand_req(1'b0, 1'b1, 13'h101), 1'b0);
        cycle(rand_req(1'b1, 1'b0, 13'h102), 1'b0);
        cycle(rand_req(1'b1, 1'b1, 13'h103), 1'b0);
        cycle(idle, 1'b0);
        chk("dual_valid_intr", 1024'(fiu_c1Tx.intrValid), 1024'(0));
        chk("dual_valid_wr", 1024'(fiu_c1Tx.wrValid), 1024'(1));
        cycle(idle, 1'b0);

        // Reset with entries queued
        for (int k = 0; k < 7; k++) cycle(rand_req(1'b1, 1'b0, 13'(k + 'h200)), 1'b1);
        chk("pre_reset_occ", 1024'(occupancy), 1024'(7));
        do_reset();
        repeat (10) cycle(idle, 1'b0);

        // Randomized traffic with a well-behaved AFU
        for (int k = 0; k < 400; k++) begin
            fa = ($urandom_range(0, 3) == 0);
            if (!exp_af && ($urandom_range(0, 2) != 0)) begin
                case ($urandom_range(0, 3))
                    0, 1: r = rand_req(1'b1, 1'b0, 13'($urandom()));
                    2:    r = rand_req(1'b0, 1'b1, 13'($urandom()));
                    default: r = rand_req(1'b1, 1'b1, 13'($urandom()));
                endcase
            end else begin
                r = idle;
            end
            cycle(r, fa);
        end
        i = 0;
        while (q.size() > 0 && i < 64) begin
            cycle(idle, 1'b0);
            i++;
        end
        chk("final_drain", 1024'(q.size()), 1024'(0));

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
